// File: rtl/cylon_scan_controller_if.sv
// Host command channel for the cylon scan controller.
// Carries mode/direction commands under a valid/ready handshake.
//   cmd_valid : host command present
//   cmd_mode  : 0 = bounce, 1 = wrap
//   cmd_dir   : 0 = LEFT (increasing index), 1 = RIGHT
//   cmd_ready : controller can accept a command
interface cylon_scan_controller_if;
    logic cmd_valid;
    logic cmd_mode;
    logic cmd_dir;
    logic cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_mode,
        output cmd_dir,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_mode,
        input  cmd_dir,
        output cmd_ready
    );
endinterface

// File: rtl/cylon_scan_controller.sv
// Scan sequencer for the 8-LED PWM cylon bank.
// Owns scan position, direction and step timing; emits 4-bit levels.
//   oneMHzClock : system clock, rising edge
//   reset       : synchronous, active-high
//   enable      : 1 = prescaler runs, 0 = everything frozen
//   cmd         : host command channel (slave side)
//   position    : current scan index 0..7
//   direction   : 0 = LEFT (increasing index), 1 = RIGHT
//   levels      : LED i level at [4i+3:4i]
//   levels_load : one-cycle pulse after each step
module cylon_scan_controller #(
    parameter int STEP_DIV = 50000,
    parameter int CNT_BITS = 16,
    parameter int PEAK     = 15,
    parameter int TAIL1    = 3,
    parameter int TAIL2    = 1
) (
    input  logic                          oneMHzClock,
    input  logic                          reset,
    input  logic                          enable,
    cylon_scan_controller_if.slave        cmd,
    output logic [2:0]                    position,
    output logic                          direction,
    output logic [31:0]                   levels,
    output logic                          levels_load
);

    localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(STEP_DIV - 1);
    localparam logic [3:0] LV_PEAK  = 4'(PEAK);
    localparam logic [3:0] LV_TAIL1 = 4'(TAIL1);
    localparam logic [3:0] LV_TAIL2 = 4'(TAIL2);

    logic [CNT_BITS-1:0] count;
    logic                mode;
    logic                pend_valid;
    logic                pend_mode;
    logic                pend_dir;

    logic                step;
    logic                apply;
    logic                accept;
    logic                eff_mode;
    logic                eff_dir;
    logic [2:0]          nxt_pos;
    logic                nxt_dir;
    logic [31:0]         nxt_levels;
    logic [31:0]         rst_levels;

    // Ring distance folds at 4 in wrap mode: 8-d == -d in 3 bits.
    function automatic logic [3:0] level_of(
        input logic [2:0] idx,
        input logic [2:0] pos,
        input logic       wrap
    );
        logic [2:0] d;
        logic [3:0] lv;
        d = (idx >= pos) ? idx - pos : pos - idx;
        if (wrap && d > 3'd4)
            d = 3'd0 - d;
        unique case (d)
            3'd0:    lv = LV_PEAK;
            3'd1:    lv = LV_TAIL1;
            3'd2:    lv = LV_TAIL2;
            default: lv = 4'd0;
        endcase
        return lv;
    endfunction

    assign cmd.cmd_ready = ~pend_valid;

    assign step   = enable && (count == LAST);
    // pend_valid is registered, so a command accepted on this very
    // edge is not yet visible here and waits for the next step.
    assign apply  = step && pend_valid;
    assign accept = cmd.cmd_valid && ~pend_valid;

    assign eff_mode = apply ? pend_mode : mode;
    assign eff_dir  = apply ? pend_dir  : direction;

    always_comb begin
        nxt_pos = position;
        nxt_dir = eff_dir;
        if (eff_mode) begin
            nxt_pos = eff_dir ? position - 3'd1 : position + 3'd1;
        end else if (!eff_dir) begin
            if (position == 3'd7) begin
                // Only reachable after a command: reverse, then move.
                nxt_dir = 1'b1;
                nxt_pos = 3'd6;
            end else begin
                nxt_pos = position + 3'd1;
                if (nxt_pos == 3'd7)
                    nxt_dir = 1'b1;
            end
        end else begin
            if (position == 3'd0) begin
                nxt_dir = 1'b0;
                nxt_pos = 3'd1;
            end else begin
                nxt_pos = position - 3'd1;
                if (nxt_pos == 3'd0)
                    nxt_dir = 1'b0;
            end
        end
    end

    always_comb begin
        nxt_levels = '0;
        rst_levels = '0;
        for (int i = 0; i < 8; i++) begin
            nxt_levels[4*i +: 4] = level_of(3'(i), nxt_pos, eff_mode);
            rst_levels[4*i +: 4] = level_of(3'(i), 3'd0, 1'b0);
        end
    end

    always_ff @(posedge oneMHzClock) begin
        if (reset) begin
            count       <= '0;
            position    <= 3'd0;
            direction   <= 1'b0;
            mode        <= 1'b0;
            levels      <= rst_levels;
            levels_load <= 1'b0;
            pend_valid  <= 1'b0;
            pend_mode   <= 1'b0;
            pend_dir    <= 1'b0;
        end else begin
            if (enable)
                count <= step ? '0 : count + CNT_BITS'(1);
            levels_load <= step;
            if (step) begin
                position  <= nxt_pos;
                direction <= nxt_dir;
                mode      <= eff_mode;
                levels    <= nxt_levels;
            end
            if (apply) begin
                pend_valid <= 1'b0;
            end else if (accept) begin
                pend_valid <= 1'b1;
                pend_mode  <= cmd.cmd_mode;
                pend_dir   <= cmd.cmd_dir;
            end
        end
    end

endmodule

// File: tb/tb_cylon_scan_controller.sv
// Testbench for cylon_scan_controller (STEP_DIV = 4).
// Directed vector table plus randomized run against a reference model.
module tb_cylon_scan_controller;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [2:0]  position;
    logic        direction;
    logic [31:0] levels;
    logic        levels_load;

    cylon_scan_controller_if cmd_bus ();

    cylon_scan_controller #(
        .STEP_DIV (DIV),
        .CNT_BITS (16),
        .PEAK     (15),
        .TAIL1    (3),
        .TAIL2    (1)
    ) dut (
        .oneMHzClock (clk),
        .reset       (reset),
        .enable      (enable),
        .cmd         (cmd_bus),
        .position    (position),
        .direction   (direction),
        .levels      (levels),
        .levels_load (levels_load)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name,
                         input logic [37:0] act,
                         input logic [37:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got pos/dir/rdy/ld/lv=%h want %h (t=%0t)",
                     name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit md;
        bit dr;
    } cmd_t;

    int   m_pos, m_dir, m_mode, m_cnt;
    bit   m_ld;
    bit   m_ok = 0;
    cmd_t m_q[$];

    function automatic logic [31:0] m_levels(input int pos, input int wrap);
        logic [31:0] r;
        int d;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            d = (i > pos) ? i - pos : pos - i;
            if (wrap != 0 && 8 - d < d)
                d = 8 - d;
            r[4*i +: 4] = (d == 0) ? 4'd15 :
                          (d == 1) ? 4'd3  :
                          (d == 2) ? 4'd1  : 4'd0;
        end
        return r;
    endfunction

    // Bounce mode viewed as a 14-phase triangle wave.
    function automatic void m_move();
        int ph;
        if (m_mode != 0) begin
            m_pos = (m_pos + ((m_dir != 0) ? 7 : 1)) % 8;
        end else begin
            if (m_dir == 0)
                ph = m_pos;
            else
                ph = (m_pos == 0) ? 0 : 14 - m_pos;
            ph    = (ph + 1) % 14;
            m_pos = (ph <= 7) ? ph : 14 - ph;
            m_dir = (ph >= 7) ? 1 : 0;
        end
    endfunction

    function automatic void m_edge(input bit r, input bit e,
                                   input bit v, input bit md,
                                   input bit dr);
        bit stp;
        bit rdy;
        cmd_t c;
        if (r) begin
            m_pos = 0; m_dir = 0; m_mode = 0; m_cnt = 0;
            m_ld = 0; m_q.delete(); m_ok = 1;
            return;
        end
        rdy = (m_q.size() == 0);
        stp = e && (m_cnt == DIV - 1);
        if (e)
            m_cnt = stp ? 0 : m_cnt + 1;
        m_ld = stp;
        if (stp) begin
            if (m_q.size() != 0) begin
                c = m_q.pop_front();
                m_mode = c.md;
                m_dir  = c.dr;
            end
            m_move();
        end
        if (v && rdy) begin
            c.md = md;
            c.dr = dr;
            m_q.push_back(c);
        end
    endfunction

    function automatic logic [37:0] dut_vec();
        return {position, direction, cmd_bus.cmd_ready, levels_load, levels};
    endfunction

    function automatic logic [37:0] model_vec();
        return {3'(m_pos), 1'(m_dir), (m_q.size() == 0), m_ld,
                m_levels(m_pos, m_mode)};
    endfunction

    // Drive at negedge, clock one edge, compare at next negedge.
    task automatic tick(input bit r, input bit e, input bit v,
                        input bit md, input bit dr);
        reset             = r;
        enable            = e;
        cmd_bus.cmd_valid = v;
        cmd_bus.cmd_mode  = md;
        cmd_bus.cmd_dir   = dr;
        @(posedge clk);
        m_edge(r, e, v, md, dr);
        @(negedge clk);
        if (m_ok)
            check("model", dut_vec(), model_vec());
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          rst;
        bit          en;
        bit          v;
        bit          md;
        bit          dr;
        int          n;
        logic [2:0]  pos;
        bit          dir;
        bit          rdy;
        bit          ld;
        logic [31:0] lv;
    } vec_t;

    vec_t tbl[$];

    initial begin
        bit hold;
        bit hm, hd, r, e, xfer;

        reset             = 1'b1;
        enable            = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_mode  = 1'b0;
        cmd_bus.cmd_dir   = 1'b0;
        @(negedge clk);

        tbl.push_back('{1,1,0,0,0, 1, 0,0,1,0, 32'h0000013F});
        tbl.push_back('{0,1,0,0,0, 3, 0,0,1,0, 32'h0000013F});
        tbl.push_back('{0,1,0,0,0, 1, 1,0,1,1, 32'h000013F3});
        tbl.push_back('{0,1,0,0,0, 1, 1,0,1,0, 32'h000013F3});
        tbl.push_back('{0,1,0,0,0, 1, 1,0,1,0, 32'h000013F3});
        tbl.push_back('{0,0,0,0,0,10, 1,0,1,0, 32'h000013F3});
        tbl.push_back('{0,1,0,0,0, 1, 1,0,1,0, 32'h000013F3});
        tbl.push_back('{0,1,0,0,0, 1, 2,0,1,1, 32'h00013F31});
        tbl.push_back('{0,1,0,0,0,16, 6,0,1,1, 32'h3F310000});
        tbl.push_back('{0,1,1,1,0, 1, 6,0,0,0, 32'h3F310000});
        tbl.push_back('{0,1,0,0,0, 3, 7,0,1,1, 32'hF3100013});
        tbl.push_back('{0,1,0,0,0, 4, 0,0,1,1, 32'h3100013F});
        tbl.push_back('{0,1,0,0,0, 3, 0,0,1,0, 32'h3100013F});
        tbl.push_back('{0,1,1,0,0, 1, 1,0,0,1, 32'h100013F3});
        tbl.push_back('{0,1,1,1,1, 1, 1,0,0,0, 32'h100013F3});
        tbl.push_back('{0,1,0,0,0, 3, 2,0,1,1, 32'h00013F31});
        tbl.push_back('{0,1,0,0,0,12, 5,0,1,1, 32'h13F31000});
        tbl.push_back('{0,1,1,1,1, 1, 5,0,0,0, 32'h13F31000});
        tbl.push_back('{1,1,0,0,0, 1, 0,0,1,0, 32'h0000013F});
        tbl.push_back('{0,1,0,0,0, 4, 1,0,1,1, 32'h000013F3});
        tbl.push_back('{0,1,0,0,0,24, 7,1,1,1, 32'hF3100000});
        tbl.push_back('{0,1,0,0,0, 4, 6,1,1,1, 32'h3F310000});
        tbl.push_back('{0,1,1,1,0, 1, 6,1,0,0, 32'h3F310000});
        tbl.push_back('{0,1,0,0,0, 3, 7,0,1,1, 32'hF3100013});
        tbl.push_back('{0,1,1,0,0, 1, 7,0,0,0, 32'hF3100013});
        tbl.push_back('{0,1,0,0,0, 3, 6,1,1,1, 32'h3F310000});

        foreach (tbl[k]) begin
            for (int c = 0; c < tbl[k].n; c++)
                tick(tbl[k].rst, tbl[k].en, tbl[k].v,
                     tbl[k].md, tbl[k].dr);
            check($sformatf("vec%0d", k), dut_vec(),
                  {tbl[k].pos, tbl[k].dir, tbl[k].rdy,
                   tbl[k].ld, tbl[k].lv});
        end

        // Randomized host traffic; host holds valid/data until taken.
        hold = 1'b0;
        hm   = 1'b0;
        hd   = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            r = ($urandom_range(0, 149) == 0);
            e = ($urandom_range(0, 7) != 0);
            if (!hold && $urandom_range(0, 5) == 0) begin
                hold = 1'b1;
                hm   = 1'($urandom_range(0, 1));
                hd   = 1'($urandom_range(0, 1));
            end
            xfer = hold && !r && (m_q.size() == 0);
            tick(r, e, hold, hm, hd);
            if (xfer || r)
                hold = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
